// File: rtl/instr_mem.sv
// Instruction memory responder for the fetch port. Fetches return after a fixed number of
// wait states; a byte-enabled write port is live in every state.
module instr_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        flush,
  output logic        busy,
  output logic        data_valid,
  output logic [31:0] rdata,
  output logic        misalign_err,
  output logic        range_err,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_data
);

  localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] ByteLimit = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WaitInit  = 4'(WAIT_STATES);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_data_q, pend_data_d;
  logic        pend_mis_q, pend_mis_d;
  logic        pend_rng_q, pend_rng_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        rng_q, rng_d;

  logic        accept;
  logic        cap_mis, cap_rng;
  logic [31:0] cap_data;
  logic        wr_ok;

  // Word is captured at accept so later writes cannot disturb it.
  assign cap_mis  = (addr[1:0] != 2'b00);
  assign cap_rng  = ({1'b0, addr} >= ByteLimit);
  assign cap_data = (cap_mis || cap_rng) ? NOP_WORD : mem[addr[IdxW+1:2]];

  assign accept = req && ((state_q != StWait) || flush);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_data_d = pend_data_q;
    pend_mis_d  = pend_mis_q;
    pend_rng_d  = pend_rng_q;
    rdata_d     = rdata_q;
    mis_d       = mis_q;
    rng_d       = rng_q;
    if (accept) begin
      cnt_d       = WaitInit;
      pend_data_d = cap_data;
      pend_mis_d  = cap_mis;
      pend_rng_d  = cap_rng;
      if (WAIT_STATES == 0) begin
        state_d = StResp;
        rdata_d = cap_data;
        mis_d   = cap_mis;
        rng_d   = cap_rng;
      end else begin
        state_d = StWait;
      end
    end else begin
      unique case (state_q)
        StWait: begin
          if (flush) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
          end else if (cnt_q == 4'd1) begin
            state_d = StResp;
            cnt_d   = 4'd0;
            rdata_d = pend_data_q;
            mis_d   = pend_mis_q;
            rng_d   = pend_rng_q;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        StResp:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      pend_data_q <= 32'd0;
      pend_mis_q  <= 1'b0;
      pend_rng_q  <= 1'b0;
      rdata_q     <= 32'd0;
      mis_q       <= 1'b0;
      rng_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_data_q <= pend_data_d;
      pend_mis_q  <= pend_mis_d;
      pend_rng_q  <= pend_rng_d;
      rdata_q     <= rdata_d;
      mis_q       <= mis_d;
      rng_q       <= rng_d;
    end
  end

  // Array is deliberately not reset; out-of-range writes are dropped.
  assign wr_ok = ({1'b0, wr_addr} < ByteLimit);

  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr[IdxW+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign busy         = (state_q == StWait);
  assign data_valid   = (state_q == StResp);
  assign rdata        = rdata_q;
  assign misalign_err = mis_q;
  assign range_err    = rng_q;

endmodule

// File: tb/tb_instr_mem.sv
// Scoreboard bench for instr_mem: three instances (0, 1 and 3 wait states) share one
// stimulus stream and are each checked against a transaction-level reference model.
module tb_instr_mem;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 6;
  localparam int unsigned NDUT  = 3;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] LIMIT = 32'(4 * DW);

  function automatic int unsigned ws_of(int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = 32'd0;
  logic [3:0]  wr_be = 4'd0;
  logic [31:0] wr_data = 32'd0;

  logic        busy_w [NDUT];
  logic        dv_w   [NDUT];
  logic        mis_w  [NDUT];
  logic        rng_w  [NDUT];
  logic [31:0] rdata_w[NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    instr_mem #(
      .DEPTH_WORDS(DW),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3)),
      .NOP_WORD   (NOP)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .addr        (addr),
      .flush       (flush),
      .busy        (busy_w[g]),
      .data_valid  (dv_w[g]),
      .rdata       (rdata_w[g]),
      .misalign_err(mis_w[g]),
      .range_err   (rng_w[g]),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_be       (wr_be),
      .wr_data     (wr_data)
    );
  end

  typedef struct {
    int          d;
    int unsigned resp;
    logic [31:0] data;
    logic        mis;
    logic        rng;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m  [DW];
  logic [31:0] last_rd[NDUT];
  logic        last_mis[NDUT];
  logic        last_rng[NDUT];
  int unsigned cur = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          mi;
  bit          ev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cur, act, exp);
    end
  endtask

  // A fetch is outstanding in its wait phase while its response cycle is still ahead.
  function automatic bit m_busy(int d, int unsigned c);
    foreach (sb[i]) if (sb[i].d == d && sb[i].resp > c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int find(int d);
    foreach (sb[i]) if (sb[i].d == d) return i;
    return -1;
  endfunction

  function automatic exp_t mk(int d, int unsigned c, logic [31:0] a);
    exp_t e;
    e.d    = d;
    e.resp = c + ws_of(d) + 1;
    e.mis  = (a[1:0] != 2'b00);
    e.rng  = (a >= LIMIT);
    e.data = (e.mis || e.rng) ? NOP : mem_m[a[AW+1:2]];
    return e;
  endfunction

  always @(negedge rst) begin
    sb.delete();
    for (int d = 0; d < NDUT; d++) begin
      last_rd[d]  = 32'd0;
      last_mis[d] = 1'b0;
      last_rng[d] = 1'b0;
    end
  end

  // Reference model: evaluates the edge that ends cycle 'cur'.
  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (rst && flush) begin
        for (int i = sb.size() - 1; i >= 0; i--)
          if (sb[i].d == d && sb[i].resp > cur) sb.delete(i);
      end
      if (rst && req && (flush || !m_busy(d, cur))) sb.push_back(mk(d, cur, addr));
    end
    if (wr_en && wr_addr < LIMIT) begin
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) mem_m[wr_addr[AW+1:2]][8*b +: 8] = wr_data[8*b +: 8];
    end
    cur++;
  end

  // Monitor: compares every presented response and the held outputs each cycle.
  always @(negedge clk) begin
    if (cur != 0) begin
      for (int d = 0; d < NDUT; d++) begin
        mi = find(d);
        ev = (mi >= 0) && (sb[mi].resp == cur);
        chk($sformatf("dut%0d busy", d), 32'(busy_w[d]), 32'(m_busy(d, cur)));
        chk($sformatf("dut%0d data_valid", d), 32'(dv_w[d]), 32'(ev));
        if (ev) begin
          last_rd[d]  = sb[mi].data;
          last_mis[d] = sb[mi].mis;
          last_rng[d] = sb[mi].rng;
          sb.delete(mi);
        end
        chk($sformatf("dut%0d rdata", d), rdata_w[d], last_rd[d]);
        chk($sformatf("dut%0d misalign_err", d), 32'(mis_w[d]), 32'(last_mis[d]));
        chk($sformatf("dut%0d range_err", d), 32'(rng_w[d]), 32'(last_rng[d]));
      end
    end
  end

  task automatic drive(input bit r, input logic [31:0] a, input bit f, input bit w,
                       input logic [31:0] wa, input logic [3:0] be, input logic [31:0] wd);
    req     = r;
    addr    = a;
    flush   = f;
    wr_en   = w;
    wr_addr = wa;
    wr_be   = be;
    wr_data = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
  endtask

  task automatic fetch(input logic [31:0] a);
    drive(1'b1, a, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k = $urandom_range(0, 19);
    if (k == 0) return 32'hFFFF_FFFC;
    if (k == 1) return LIMIT + 32'($urandom_range(0, 3));
    if (k < 5) return 32'($urandom_range(0, 4 * DW - 1));
    return 32'($urandom_range(0, DW - 1)) << 2;
  endfunction

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < DW; i++) begin
      drive(1'b0, 32'd0, 1'b0, 1'b1, 32'(i * 4), 4'hF,
            (i == 4) ? 32'hDEAD_BEEF : ((i == 8) ? 32'h8888_0008 : $urandom()));
    end

    // Single fetch of word 4.
    fetch(32'h10);
    idle(5);
    chk("ws1 fetch 0x10", rdata_w[1], 32'hDEAD_BEEF);

    // Request held over consecutive addresses.
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    idle(10);

    // Error responses.
    fetch(32'h6);
    idle(6);
    chk("misaligned rdata", rdata_w[0], NOP);
    chk("misaligned flag", 32'(mis_w[0]), 32'd1);
    fetch(LIMIT);
    idle(6);
    chk("range rdata", rdata_w[0], NOP);
    chk("range flag", 32'(rng_w[0]), 32'd1);

    // Redirect two cycles into a three-wait-state fetch.
    fetch(32'h0);
    idle(1);
    drive(1'b1, 32'h20, 1'b1, 1'b0, 32'd0, 4'd0, 32'd0);
    idle(7);
    chk("ws3 flush redirect", rdata_w[2], 32'h8888_0008);

    // Partial write, then read-before-write on the accept edge.
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h10, 4'b0011, 32'h1234_5678);
    fetch(32'h10);
    idle(6);
    chk("byte-enable merge", rdata_w[1], 32'hDEAD_5678);
    drive(1'b1, 32'h10, 1'b0, 1'b1, 32'h10, 4'hF, 32'hCAFE_F00D);
    idle(6);
    chk("read before write", rdata_w[1], 32'hDEAD_5678);
    fetch(32'h10);
    idle(6);
    chk("written word", rdata_w[1], 32'hCAFE_F00D);

    repeat (2000) begin
      drive($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 9) == 0,
            $urandom_range(0, 4) == 0,
            ($urandom_range(0, 7) == 0) ? 32'(LIMIT + 32'($urandom_range(0, 64)))
                                        : 32'($urandom_range(0, 4 * DW - 1)),
            4'($urandom_range(0, 15)), $urandom());
    end
    idle(6);

    // Asynchronous reset in the middle of a wait.
    fetch(32'h14);
    req = 1'b0;
    chk("ws3 busy before reset", 32'(busy_w[2]), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("reset busy", 32'(busy_w[2]), 32'd0);
    chk("reset data_valid ws0", 32'(dv_w[0]), 32'd0);
    chk("reset rdata ws3", rdata_w[2], 32'd0);
    chk("reset rdata ws0", rdata_w[0], 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(8);

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
